// File: rtl/crc_pkg.sv
// Shared types and constants for the WimpFi transmit CRC sequencer.
// Dallas/Maxim CRC-8, reflected form, LSB-first.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        EMIT,
        EMIT_CRC
    } state_t;

    localparam int         BYTE_W        = 8;
    localparam logic [7:0] CRC_POLY_REFL = 8'h8C;
    localparam logic [7:0] CRC_INIT      = 8'h00;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial Dallas/Maxim CRC-8 LFSR (x^8+x^5+x^4+1).
// One data bit per enabled cycle; clr wins over enb.
module crc8_serial
    import crc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       enb,
    input  logic       d,
    output logic [7:0] crc
);

    logic fb;

    assign fb = crc[0] ^ d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (enb) begin
            crc <= (crc >> 1) ^ (fb ? CRC_POLY_REFL : 8'h00);
        end
    end

endmodule

// File: rtl/crc_frame_seq.sv
// Transmit CRC sequencer: echoes frame bytes and appends a CRC-8 byte.
// Optional receive-check mode is enabled with the CRC_CHECK_EN macro.
module crc_frame_seq
    import crc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
`ifdef CRC_CHECK_EN
    input  logic              check_mode,
    output logic              crc_ok,
`endif
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic [BYTE_W-1:0] hold;
    logic              last_q;
    logic              busy_q;
    logic              chk_q;
    logic [7:0]        crc;

    logic accept;
    logic out_hs;
    logic final_hs;
    logic lfsr_en;
    logic lfsr_d;

    crc8_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (final_hs),
        .enb (lfsr_en),
        .d   (lfsr_d),
        .crc (crc)
    );

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == EMIT) || (state == EMIT_CRC);
        out_data  = (state == EMIT_CRC) ? crc : hold;
        out_last  = (state == EMIT_CRC)
                 || ((state == EMIT) && last_q && chk_q);
        accept    = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        final_hs  = out_hs && out_last;
        lfsr_en   = (state == SHIFT);
        lfsr_d    = hold[cnt];
        busy      = busy_q;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == 3'd7) state_nxt = EMIT;
            end
            EMIT: begin
                if (out_hs) begin
                    state_nxt = (last_q && !chk_q) ? EMIT_CRC : IDLE;
                end
            end
            EMIT_CRC: begin
                if (out_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            hold   <= '0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == SHIFT) cnt <= cnt + 3'd1;
            if (accept) begin
                hold   <= in_data;
                last_q <= in_last;
            end
            if (accept) begin
                busy_q <= 1'b1;
            end else if (final_hs) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef CRC_CHECK_EN
    // Mode is taken from the first byte only and held for the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= 1'b0;
        end else if (accept && !busy_q) begin
            chk_q <= check_mode;
        end
    end

    assign crc_ok = final_hs && chk_q && (state == EMIT) && (crc == 8'h00);
`else
    assign chk_q = 1'b0;
`endif

endmodule

// File: tb/tb_crc_frame_seq.sv
// Self-checking bench for crc_frame_seq (scoreboard of expected bytes).
// Check-mode scenarios build only when CRC_CHECK_EN is defined.
module tb_crc_frame_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
`ifdef CRC_CHECK_EN
    logic       check_mode;
    logic       crc_ok;
`endif

    int         total = 0;
    int         bad = 0;
    logic [8:0] expq[$];
    logic [7:0] frm[16];
    longint     t_first;
    longint     t_final;

    always #5 clk = ~clk;

    crc_frame_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
`ifdef CRC_CHECK_EN
        .check_mode (check_mode),
        .crc_ok     (crc_ok),
`endif
        .busy       (busy)
    );

    function automatic logic [7:0] crc_ref(input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ frm[i][j];
                c  = {1'b0, c[7:1]};
                if (fb) c = c ^ 8'h8C;
            end
        end
        return c;
    endfunction

    task automatic wait_out(input bit stall, input bit ok_exp, input bit junk);
        int         k;
        bit         stalled;
        bit         done;
        logic [7:0] pd;
        logic       pl;
        logic [8:0] e;
        k = 0;
        stalled = 0;
        done = 0;
        pd = 8'h00;
        pl = 1'b0;
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            in_last  = 1'b1;
        end
        while (!done) begin
            out_ready = !stall || (k % 3 == 2);
            #1;
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL in_ready_busy: got %b want 0", in_ready);
            end
            if (stalled) begin
                total++;
                if (out_data !== pd || out_last !== pl) begin
                    bad++;
                    $display("FAIL stall_stable: got %h/%b want %h/%b",
                             out_data, out_last, pd, pl);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL extra_byte: got %h want none", out_data);
                end else begin
                    e = expq.pop_front();
                    if ({out_last, out_data} !== e) begin
                        bad++;
                        $display("FAIL out_byte: got last=%b data=%h want last=%b data=%h",
                                 out_last, out_data, e[8], e[7:0]);
                    end
`ifdef CRC_CHECK_EN
                    total++;
                    if (crc_ok !== (e[8] & ok_exp)) begin
                        bad++;
                        $display("FAIL crc_ok: got %b want %b", crc_ok, e[8] & ok_exp);
                    end
`endif
                end
                t_final = $time + 4;
                done = 1;
            end else begin
                stalled = out_valid;
                pd = out_data;
                pl = out_last;
            end
            @(negedge clk);
            k++;
            if (!done && k > 200) begin
                total++;
                bad++;
                $display("FAIL out_timeout: got no handshake want one within 200 cycles");
                done = 1;
            end
        end
    endtask

    task automatic run_frame(input int n, input bit stall, input bit chk,
                             input logic [7:0] crc_exp, input bit ok_exp,
                             input bit junk);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = frm[i];
            in_last  = (i == n - 1);
`ifdef CRC_CHECK_EN
            check_mode = chk;
`endif
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL in_ready_idle: got %b want 1", in_ready);
            end
            expq.push_back({(i == n - 1) && chk, frm[i]});
            if (i == n - 1 && !chk) expq.push_back({1'b1, crc_exp});
            @(posedge clk);
            if (i == 0) t_first = $time;
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_set: got %b want 1", busy);
            end
            wait_out(stall, ok_exp, junk);
        end
        if (!chk) wait_out(stall, ok_exp, junk);
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || expq.size() != 0) begin
            bad++;
            $display("FAIL frame_end: got busy=%b pending=%0d want 0/0",
                     busy, expq.size());
        end
        expq.delete();
    endtask

    task automatic load7();
        frm[0] = 8'h02; frm[1] = 8'h1C; frm[2] = 8'hB8; frm[3] = 8'h01;
        frm[4] = 8'h00; frm[5] = 8'h00; frm[6] = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        out_ready = 1'b0;
`ifdef CRC_CHECK_EN
        check_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_data, out_last, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals: got rdy=%b v=%b d=%h l=%b busy=%b want 1 0 00 0 0",
                     in_ready, out_valid, out_data, out_last, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        longint span;
        frm[0] = 8'h01;
        run_frame(1, 0, 0, 8'h5E, 0, 0);
        span = (t_final - t_first) / 10 + 1;
        total++;
        if (span != 11) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles want 11", span);
        end
    endtask

    task automatic test_seven();
        longint span;
        load7();
        run_frame(7, 0, 0, 8'hA2, 0, 0);
        span = (t_final - t_first) / 10 + 1;
        total++;
        if (span != 71) begin
            bad++;
            $display("FAIL seven_latency: got %0d cycles want 71", span);
        end
    endtask

    task automatic test_stall();
        load7();
        run_frame(7, 1, 0, 8'hA2, 0, 1);
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; in_data = 8'h33; in_last = 1'b0;
        expq.push_back({1'b0, 8'h33});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(0, 0, 0);
        in_valid = 1'b1; in_data = 8'h44; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: got rdy=%b busy=%b want 0 1", in_ready, busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, out_data, out_last, busy} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset_vals: got rdy=%b v=%b d=%h l=%b busy=%b want 1 0 00 0 0",
                     in_ready, out_valid, out_data, out_last, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        @(negedge clk);
        frm[0] = 8'h01;
        run_frame(1, 0, 0, 8'h5E, 0, 0);
    endtask

    task automatic test_back_to_back();
        frm[0] = 8'h00; frm[1] = 8'h00;
        run_frame(2, 0, 0, 8'h00, 0, 0);
        frm[0] = 8'h01;
        run_frame(1, 0, 0, 8'h5E, 0, 0);
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) frm[i] = 8'($urandom);
            run_frame(n, bit'(f % 2), 0, crc_ref(n), 0, bit'(f % 2));
        end
    endtask

`ifdef CRC_CHECK_EN
    task automatic test_check_mode();
        frm[0] = 8'h01; frm[1] = 8'h5E;
        run_frame(2, 0, 1, 8'h00, 1, 0);
        frm[0] = 8'h01; frm[1] = 8'h5F;
        run_frame(2, 1, 1, 8'h00, 0, 0);
        frm[0] = 8'h01;
        run_frame(1, 0, 0, 8'h5E, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_seven();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef CRC_CHECK_EN
        test_check_mode();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
